// File: rtl/adj_btn_pkg.sv
// Shared constants for the clock-adjust button conditioner: channel indices,
// default timing and a clog2 helper for sizing the counters.
package adj_btn_pkg;

    localparam int BTN_HRS = 0;
    localparam int BTN_MIN = 1;
    localparam int BTN_SEC = 2;

    localparam int DEF_NUM_BTN         = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_REPEAT_DELAY    = 12500000;
    localparam int DEF_REPEAT_PERIOD   = 2500000;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adj_btn_channel.sv
// One button slice: 2-FF synchroniser, debounce counter and registered press strobe.
// Optional auto-repeat is built only when AUTO_REPEAT_EN is defined.
module adj_btn_channel
    import adj_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("adj_btn_channel: every count parameter must be >= 2");
    end

    logic             meta_q;
    logic             sync_q;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_on_q, rpt_on_d;
`endif

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        if (sync_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // Strobe lands on the same edge the debounced level first reads 1.
        pulse_d = level_d & ~level_q;
`ifdef AUTO_REPEAT_EN
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
        // rpt_on_q selects the first (long) delay versus the later period.
        if (level_q && level_d) begin
            rpt_on_d = rpt_on_q;
            if (rpt_cnt_q == (rpt_on_q ? RP_LAST : RD_LAST)) begin
                pulse_d  = 1'b1;
                rpt_on_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            level_q  <= 1'b0;
            pulse_q  <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            meta_q   <= btn_i;
            sync_q   <= meta_q;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            db_cnt_q <= db_cnt_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rpt_cnt_q <= '0;
            rpt_on_q  <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_on_q  <= rpt_on_d;
        end
    end
`endif

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/adj_button_conditioner.sv
// Conditions the hours/minutes/seconds adjust buttons into debounced levels and
// one-cycle press strobes. Define AUTO_REPEAT_EN to add hold-to-repeat pulses.
module adj_button_conditioner
    import adj_btn_pkg::*;
#(
    parameter int NUM_BTN         = DEF_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        adj_btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk_i   (wb_clk_i),
            .rst_i   (wb_rst_i),
            .btn_i   (btn_in[i]),
            .level_o (btn_level[i]),
            .pulse_o (btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_adj_button_conditioner.sv
// Directed bench for adj_button_conditioner: expected strobes (cycle, vector) are
// queued by the stimulus and matched by a monitor whenever btn_pulse is non-zero.
module tb_adj_button_conditioner;

    localparam int D   = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = D + 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn;
    logic [2:0] btn_level;
    logic [2:0] btn_pulse;

    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;

    adj_button_conditioner #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .btn_in    (btn),
        .btn_level (btn_level),
        .btn_pulse (btn_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    task automatic drain(input string name);
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the next queued expectation exactly.
    always @(negedge clk) begin
        if (btn_pulse !== 3'b000) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pulse_unexpected: got %b at cycle %0d, expected none", btn_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({cyc[31:0], btn_pulse} !== mon_e) begin
                    miscompares++;
                    $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                             btn_pulse, cyc, mon_e[2:0], mon_e[34:3]);
                end
            end
        end
    end

    initial begin
        int c0;
        rst = 1'b1;
        btn = 3'b000;

        // Reset held with all buttons pressed
        @(negedge clk);
        btn = 3'b111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_level", 32'(btn_level), 32'd0);
            check("rst_pulse", 32'(btn_pulse), 32'd0);
        end
        c0  = cyc;
        rst = 1'b0;
        exp_q.push_back({32'(c0 + LAT), 3'b111});
        wait_cyc(LAT + 4);
        drain("rst_release_pulses");
        check("rst_release_level", 32'(btn_level), 32'h7);
        btn = 3'b000;
        wait_cyc(LAT + 2);
        check("release_level", 32'(btn_level), 32'd0);

        // Short glitch on hours
        btn[0] = 1'b1;
        wait_cyc(5);
        btn[0] = 1'b0;
        wait_cyc(LAT + 4);
        check("glitch_level", 32'(btn_level), 32'd0);
        drain("glitch_pulses");

        // Press and hold minutes for 40 cycles
        c0 = cyc;
        btn[1] = 1'b1;
        exp_q.push_back({32'(c0 + LAT), 3'b010});
`ifdef AUTO_REPEAT_EN
        for (int t = c0 + LAT + RD; t < c0 + 40 + LAT; t += RP)
            exp_q.push_back({32'(t), 3'b010});
`endif
        wait_cyc(40);
        btn[1] = 1'b0;
        wait_cyc(LAT - 1);
        check("hold_level_before_fall", 32'(btn_level), 32'h2);
        wait_cyc(1);
        check("hold_level_after_fall", 32'(btn_level), 32'd0);
        wait_cyc(4);
        drain("hold_pulses");

        // Bouncing seconds input, toggling every 3 cycles, then settling high
        c0 = cyc;
        for (int k = 0; k < 10; k++) begin
            btn[2] = (k % 2 == 0);
            wait_cyc(3);
        end
        btn[2] = 1'b1;
        exp_q.push_back({32'(cyc + LAT), 3'b100});
        wait_cyc(LAT + 4);
        drain("bounce_pulses");
        check("bounce_level", 32'(btn_level), 32'h4);
        btn = 3'b000;
        wait_cyc(LAT + 2);
        check("bounce_release_level", 32'(btn_level), 32'd0);

        // All three pressed together
        c0 = cyc;
        btn = 3'b111;
        exp_q.push_back({32'(c0 + LAT), 3'b111});
        wait_cyc(LAT + 4);
        drain("simul_pulses");
        check("simul_level", 32'(btn_level), 32'h7);
        btn = 3'b000;
        wait_cyc(LAT + 2);
        check("simul_release_level", 32'(btn_level), 32'd0);

        // Reset pulse at debounce count 5, then full re-debounce
        c0 = cyc;
        btn[0] = 1'b1;
        wait_cyc(7);
        rst = 1'b1;
        wait_cyc(1);
        check("midrst_level", 32'(btn_level), 32'd0);
        check("midrst_pulse", 32'(btn_pulse), 32'd0);
        rst = 1'b0;
        exp_q.push_back({32'(cyc + LAT), 3'b001});
        wait_cyc(LAT + 4);
        drain("midrst_pulses");
        check("midrst_level_after", 32'(btn_level), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
